hpdmc_fmlarb: RTL and testbench

//  4-master FML 4x64 arbiter sitting directly upstream of the HPDMC FML port.

---
 rtl/hpdmc_fmlarb.sv | 129 ++++++++++++
 tb/tb_hpdmc_fmlarb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_fmlarb.sv
// Four-master FML arbiter in front of the HPDMC FML port; round robin by default.
// Define FMLARB_PRIO0_EN to give master 0 absolute priority over masters 1-3.
module hpdmc_fmlarb #(
  parameter int fml_depth = 26
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [4*fml_depth-1:0] m_adr,
  input  logic [3:0]             m_stb,
  input  logic [3:0]             m_we,
  input  logic [31:0]            m_sel,
  input  logic [255:0]           m_di,
  output logic [3:0]             m_ack,
  output logic [63:0]            m_do,
  output logic [fml_depth-1:0]   s_adr,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [7:0]             s_sel,
  output logic [63:0]            s_do,
  input  logic                   s_ack,
  input  logic [63:0]            s_di
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [1:0] grant, grant_d;
  logic [1:0] last, last_d;
  logic [1:0] beat, beat_d;
  logic [1:0] pick;
  logic [1:0] idx;

`ifdef FMLARB_PRIO0_EN
  logic [1:0] base;

  // masters 1-3 rotate after last (0 folds to 3); master 0 overrides
  always_comb begin
    base = (last == 2'd0) ? 2'd3 : last;
    pick = 2'd1;
    idx  = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      idx = 2'((int'(base) + i) % 3 + 1);
      if (m_stb[idx])
        pick = idx;
    end
    if (m_stb[0])
      pick = 2'd0;
  end
`else
  // lowest offset from last+1 wins, so scan downwards
  always_comb begin
    pick = last + 2'd1;
    idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (m_stb[idx])
        pick = idx;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      grant <= 2'd0;
      last  <= 2'd3;
      beat  <= 2'd0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      last  <= last_d;
      beat  <= beat_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last;
    beat_d  = beat;
    s_stb   = 1'b0;
    m_ack   = 4'b0000;
    unique case (state)
      IDLE: begin
        if (|m_stb) begin
          grant_d = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        s_stb = m_stb[grant];
        if (!m_stb[grant]) begin
          state_d = IDLE;
        end else if (s_ack) begin
          m_ack[grant] = 1'b1;
          last_d       = grant;
          if (m_we[grant]) begin
            state_d = WDATA;
            beat_d  = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WDATA: begin
        beat_d = beat + 2'd1;
        if (beat == 2'd2)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset kills any handshake in the same cycle
    if (sys_rst) begin
      s_stb = 1'b0;
      m_ack = 4'b0000;
    end
  end

  assign s_adr = m_adr[int'(grant)*fml_depth +: fml_depth];
  assign s_we  = m_we[grant];
  assign s_sel = m_sel[int'(grant)*8 +: 8];
  assign s_do  = m_di[int'(grant)*64 +: 64];
  assign m_do  = s_di;

endmodule

// File: tb/tb_hpdmc_fmlarb.sv
// Directed bench for hpdmc_fmlarb: reset, round robin, write burst,
// withdrawn request and reset during a burst.
module tb_hpdmc_fmlarb;

  localparam int D = 26;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [4*D-1:0] m_adr;
  logic [3:0]     m_stb;
  logic [3:0]     m_we;
  logic [31:0]    m_sel;
  logic [255:0]   m_di;
  logic [3:0]     m_ack;
  logic [63:0]    m_do;
  logic [D-1:0]   s_adr;
  logic           s_stb;
  logic           s_we;
  logic [7:0]     s_sel;
  logic [63:0]    s_do;
  logic           s_ack;
  logic [63:0]    s_di;

  int checks = 0;
  int errors = 0;

  hpdmc_fmlarb #(.fml_depth(D)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .m_adr(m_adr),
    .m_stb(m_stb),
    .m_we(m_we),
    .m_sel(m_sel),
    .m_di(m_di),
    .m_ack(m_ack),
    .m_do(m_do),
    .s_adr(s_adr),
    .s_stb(s_stb),
    .s_we(s_we),
    .s_sel(s_sel),
    .s_do(s_do),
    .s_ack(s_ack),
    .s_di(s_di)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [D-1:0] adr_of(input int i);
    return D'(26'h0100000 + 26'(i * 16'h0111));
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  int exp_g;

  initial begin
    sys_rst = 1'b1;
    m_stb   = '0;
    m_we    = '0;
    m_sel   = 32'h4433_2211;
    m_di    = '0;
    s_ack   = 1'b0;
    s_di    = '0;
    for (int i = 0; i < 4; i++)
      m_adr[i*D +: D] = adr_of(i);

    // 1: single read from master 0
    next();
    next();
    @(negedge sys_clk);
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    next();
    sys_rst = 1'b0;
    m_stb   = 4'b0001;
    @(negedge sys_clk);
    chk("t1_idle", 64'(s_stb), 64'd0);
    next();
    @(negedge sys_clk);
    chk("t1_stb", 64'(s_stb), 64'd1);
    chk("t1_adr", 64'(s_adr), 64'(adr_of(0)));
    chk("t1_noack", 64'(m_ack), 64'd0);
    next();
    s_ack = 1'b1;
    s_di  = 64'hDEAD_BEEF_0123_4567;
    @(negedge sys_clk);
    chk("t1_ack", 64'(m_ack), 64'h1);
    chk("t1_do", m_do, 64'hDEAD_BEEF_0123_4567);
    next();
    s_ack = 1'b0;
    m_stb = 4'b0000;
    @(negedge sys_clk);
    chk("t1_back", 64'(s_stb), 64'd0);
    chk("t1_back_ack", 64'(m_ack), 64'd0);

    // 2/6: all masters requesting, immediate acks
    next();
    sys_rst = 1'b1;
    next();
    sys_rst = 1'b0;
    m_stb   = 4'b1111;
    s_ack   = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef FMLARB_PRIO0_EN
      exp_g = 0;
`else
      exp_g = k % 4;
`endif
      @(negedge sys_clk);
      chk("t2_idle", 64'(m_ack), 64'd0);
      next();
      @(negedge sys_clk);
      chk("t2_ack", 64'(m_ack), 64'(oh(exp_g)));
      chk("t2_adr", 64'(s_adr), 64'(adr_of(exp_g)));
      next();
    end
    m_stb = 4'b0000;
    s_ack = 1'b0;

    // 3: master 2 write burst
    m_stb = 4'b0100;
    m_we  = 4'b0100;
    m_di[128 +: 64] = 64'hAAAA_0000_0000_000A;
    @(negedge sys_clk);
    next();
    s_ack = 1'b1;
    @(negedge sys_clk);
    chk("t3_ack", 64'(m_ack), 64'h4);
    chk("t3_we", 64'(s_we), 64'd1);
    chk("t3_sel", 64'(s_sel), 64'h33);
    chk("t3_beatA", s_do, 64'hAAAA_0000_0000_000A);
    next();
    s_ack = 1'b0;
    m_di[128 +: 64] = 64'hBBBB_0000_0000_000B;
    @(negedge sys_clk);
    chk("t3_beatB", s_do, 64'hBBBB_0000_0000_000B);
    chk("t3_stbB", 64'(s_stb), 64'd0);
    next();
    m_di[128 +: 64] = 64'hCCCC_0000_0000_000C;
    @(negedge sys_clk);
    chk("t3_beatC", s_do, 64'hCCCC_0000_0000_000C);
    chk("t3_stbC", 64'(s_stb), 64'd0);
    next();
    m_di[128 +: 64] = 64'hDDDD_0000_0000_000D;
    @(negedge sys_clk);
    chk("t3_beatD", s_do, 64'hDDDD_0000_0000_000D);
    chk("t3_stbD", 64'(s_stb), 64'd0);
    next();
    @(negedge sys_clk);
    chk("t3_gap", 64'(s_stb), 64'd0);
    next();
    @(negedge sys_clk);
    chk("t3_rereq", 64'(s_stb), 64'd1);
    next();
    m_stb = 4'b0000;
    m_we  = 4'b0000;
    @(negedge sys_clk);
    chk("t3_wdraw", 64'(s_stb), 64'd0);

    // 4: master 1 withdraws before ack; last stays 2
    next();
    m_stb = 4'b0010;
    @(negedge sys_clk);
    next();
    @(negedge sys_clk);
    chk("t4_stb", 64'(s_stb), 64'd1);
    chk("t4_adr", 64'(s_adr), 64'(adr_of(1)));
    next();
    m_stb = 4'b0000;
    s_ack = 1'b1;
    @(negedge sys_clk);
    chk("t4_noack", 64'(m_ack), 64'd0);
    chk("t4_nostb", 64'(s_stb), 64'd0);
    next();
    m_stb = 4'b1111;
    s_ack = 1'b0;
    @(negedge sys_clk);
    chk("t4_idle", 64'(s_stb), 64'd0);
    next();
    s_ack = 1'b1;
`ifdef FMLARB_PRIO0_EN
    exp_g = 0;
`else
    exp_g = 3;
`endif
    @(negedge sys_clk);
    chk("t4_next", 64'(m_ack), 64'(oh(exp_g)));
    next();
    m_stb = 4'b0000;
    s_ack = 1'b0;

    // 5: reset during WDATA beat 1
    m_stb = 4'b0001;
    m_we  = 4'b0001;
    @(negedge sys_clk);
    next();
    s_ack = 1'b1;
    @(negedge sys_clk);
    chk("t5_ack", 64'(m_ack), 64'h1);
    next();
    s_ack = 1'b0;
    m_stb = 4'b0000;
    m_we  = 4'b0000;
    @(negedge sys_clk);
    next();
    sys_rst = 1'b1;
    m_stb   = 4'b1111;
    s_ack   = 1'b1;
    @(negedge sys_clk);
    chk("t5_rst_stb", 64'(s_stb), 64'd0);
    chk("t5_rst_ack", 64'(m_ack), 64'd0);
    next();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_idle_stb", 64'(s_stb), 64'd0);
    chk("t5_idle_ack", 64'(m_ack), 64'd0);
    next();
    @(negedge sys_clk);
    chk("t5_last", 64'(m_ack), 64'h1);
    next();
    m_stb = 4'b0000;
    s_ack = 1'b0;
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
